// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and the memory.
// The fetch unit drives the address and request and waits for a one-cycle
// acknowledge that carries the read data.
interface instr_fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_rd_req;
  logic [31:0] mem_rd_data;
  logic        mem_rd_ack;

  modport master (
    output mem_addr,
    output mem_rd_req,
    input  mem_rd_data,
    input  mem_rd_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_req,
    output mem_rd_data,
    output mem_rd_ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multi-cycle MIPS datapath.
// Owns the PC and the instruction register, issues word reads over a
// variable-latency req/ack bus, and slices the IR into decode fields.
// A request that is not acknowledged within TIMEOUT cycles, or a fetch from
// a misaligned PC, parks the unit in a terminal FAULT state until reset.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_start,
  input  logic                       pc_write,
  input  logic [31:0]                pc_next,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  output logic [31:0]                instr,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [15:0]                imm16,
  output logic                       instr_valid,
  output logic                       busy,
  output logic                       fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Last wait-counter value at which a missing ack becomes a fault.
  // The counter starts at 0 in the first request cycle, so the request
  // stays up for exactly TIMEOUT cycles before the unit gives up.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] pc_inc;

  // Sequential PC increment, shared by the pc_plus4 output and the fetch
  // completion path; wraps modulo 2^32.
  assign pc_inc = pc_q + 32'd4;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0000;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and next-register logic: hold everything by default, the
  // valid strobe defaults low so it can only ever be a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    req_d      = req_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    fault_d    = fault_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // A fetch request wins over a simultaneous PC load; the load is
        // simply dropped. Alignment is checked here rather than at the
        // PC load so that branch targets need no extra logic.
        if (fetch_start) begin
          if (pc_q[1:0] == 2'b00) begin
            state_d    = ST_FETCH;
            req_d      = 1'b1;
            busy_d     = 1'b1;
            wait_cnt_d = 8'd0;
          end else begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end
        end else if (pc_write) begin
          pc_d = pc_next;
        end
      end

      ST_FETCH: begin
        // An ack on the threshold cycle still completes normally, so it is
        // tested before the timeout.
        if (imem.mem_rd_ack) begin
          state_d = ST_IDLE;
          instr_d = imem.mem_rd_data;
          pc_d    = pc_inc;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_FAULT;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_FAULT: begin
        // Terminal until reset: every input is ignored and PC/IR hold.
        req_d  = 1'b0;
        busy_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Memory bus: the address is the PC itself, which cannot change while a
  // request is outstanding because PC loads are only accepted in IDLE.
  assign imem.mem_addr   = pc_q;
  assign imem.mem_rd_req = req_q;

  // Architectural outputs.
  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

  // Decode fields are pure slices of the IR and move only when it loads.
  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign funct  = instr_q[5:0];
  assign imm16  = instr_q[15:0];

endmodule
